branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Dynamic branch predictor for the RV32I pipeline: a direct-mapped BTB combined with a 2-bit saturating-counter BHT.
- IF side: looks up PC_IF combinationally and supplies a predicted next PC that the IF-stage PC mux uses.
- EX side: receives resolved branch outcomes, updates the tables, and signals mispredict plus the corrected PC so the hazard unit can flush IF/ID.

Parameters:
- ENTRY_BITS, 6, log2 of entry count (64 entries). index = PC[ENTRY_BITS+1:2]; tag = PC[31:ENTRY_BITS+2].

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- PC_IF  input  32  fetch PC
- pred_taken  output  1  1 = predict taken for PC_IF
- pred_target  output  32  predicted next PC (target if taken, else PC_IF+4)
- br_EX  input  1  instruction in EX is a conditional branch
- br_taken_EX  input  1  resolved branch direction
- PC_EX  input  32  PC of the EX instruction
- br_target_EX  input  32  resolved branch target
- pred_taken_EX  input  1  prediction carried down the pipeline with this instruction; pipeline forces 0 on bubbles and flushes
- pred_target_EX  input  32  predicted next PC carried down the pipeline
- mispredict  output  1  flush request
- redirect_pc  output  32  correct next PC when mispredict=1

Behaviour:
- Storage per entry: valid, tag (32-ENTRY_BITS-2 bits), target[31:0], cnt[1:0]. Implemented in flops, not RAM.
- Lookup (combinational, zero latency):
  - hit = valid[idx] & tag match.
  - pred_taken = hit & cnt[1].
  - pred_target = pred_taken ? target : PC_IF+4 (32-bit wrap).
- Mispredict (combinational):
  - mispredict = (br_EX & (br_taken_EX != pred_taken_EX)) | (br_EX & br_taken_EX & pred_taken_EX & (pred_target_EX != br_target_EX)) | (!br_EX & pred_taken_EX).
  - redirect_pc = (br_EX & br_taken_EX) ? br_target_EX : PC_EX+4.
- Update on rising edge (EX index/tag taken from PC_EX):
  - br_EX & hit: cnt saturating +1 if taken, -1 if not; 11 stays 11, 00 stays 00. If taken, target <= br_target_EX.
  - br_EX & miss & taken: allocate. valid=1, tag, target, cnt=10 (weakly taken); overwrites any conflicting entry.
  - br_EX & miss & not taken: no change.
  - !br_EX & pred_taken_EX (alias, non-branch predicted taken): valid[idx] <= 0.
  - Otherwise: no state change.
- Same-cycle read/write: the IF lookup sees pre-update state; there is no bypass. A same-index update is visible the next cycle.
- Reset:
  - All valid <= 0 and cnt <= 01 in one cycle; tag and target are don't-care.
  - rst has priority over any same-cycle update.
  - Outputs are combinational, so after reset pred_taken=0 and pred_target=PC_IF+4.
  - Reset asserted mid-stream discards the pending update.
- The block never stalls and has no handshake; one update per cycle at most.

Optional Feature:
- Macro: BP_STATS_EN
- Defined: adds output ports br_count[31:0] and mispred_count[31:0].
  - br_count increments each cycle with br_EX=1.
  - mispred_count increments each cycle with mispredict=1.
  - Both reset to 0 on rst and wrap modulo 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Cold miss, taken: rst, then PC_IF=0x40 -> pred_taken=0, pred_target=0x44. EX br_EX=1, br_taken_EX=1, PC_EX=0x40, br_target_EX=0x100, pred_taken_EX=0 -> mispredict=1, redirect_pc=0x100. Next cycle PC_IF=0x40 -> pred_taken=1, pred_target=0x100.
- Saturation/hysteresis: from allocated (cnt=10), 2 taken updates then 1 not-taken.
  - Still predicts taken (cnt 11->10); mispredict=1 on the not-taken update, redirect_pc=0x44.
  - A second not-taken gives cnt=01, so pred_taken=0.
- Wrong target: hit entry 0x40->0x100. EX taken with br_target_EX=0x200, pred_taken_EX=1, pred_target_EX=0x100 -> mispredict=1, redirect_pc=0x200. Next lookup pred_target=0x200.
- Conflict and alias:
  - Taken branch at 0x140 (same index 16, tag 1) evicts 0x40; lookup 0x40 -> pred_taken=0.
  - Then a non-branch at 0x140 with pred_taken_EX=1 -> mispredict=1, redirect_pc=0x144, entry invalidated.
- Simultaneous read/write plus reset: update for 0x40 in the same cycle as PC_IF=0x40 -> old prediction that cycle, new one next.
  - rst asserted with br_EX=1 -> entry not allocated; all lookups miss afterwards.
- BP_STATS_EN: 10 branches including 3 mispredicts -> br_count=10, mispred_count=3. rst -> both 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating-counter BHT: zero-latency IF lookup, EX-side update and mispredict detection.
// Optional BP_STATS_EN macro adds branch / mispredict event counters as extra output ports.
module branch_predictor #(
   parameter int ENTRY_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PC_IF,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        br_EX,
   input  logic        br_taken_EX,
   input  logic [31:0] PC_EX,
   input  logic [31:0] br_target_EX,
   input  logic        pred_taken_EX,
   input  logic [31:0] pred_target_EX,
   output logic        mispredict,
   output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
   ,
   output logic [31:0] br_count,
   output logic [31:0] mispred_count
`endif
);

   localparam int ENTRIES = 1 << ENTRY_BITS;
   localparam int TAG_W   = 32 - ENTRY_BITS - 2;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_d    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [31:0]        target_d [ENTRIES];
   logic [1:0]         cnt_q    [ENTRIES];
   logic [1:0]         cnt_d    [ENTRIES];

   logic [ENTRY_BITS-1:0] if_idx;
   logic [TAG_W-1:0]      if_tag;
   logic                  if_hit;
   logic [ENTRY_BITS-1:0] ex_idx;
   logic [TAG_W-1:0]      ex_tag;
   logic                  ex_hit;
   logic                  unused_pc_low;

   assign if_idx = PC_IF[ENTRY_BITS+1:2];
   assign if_tag = PC_IF[31:ENTRY_BITS+2];
   assign ex_idx = PC_EX[ENTRY_BITS+1:2];
   assign ex_tag = PC_EX[31:ENTRY_BITS+2];
   assign unused_pc_low = ^{PC_IF[1:0], PC_EX[1:0]};

   // Lookup reads pre-update state; there is deliberately no write-to-read bypass.
   always_comb begin
      if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      pred_taken  = if_hit && cnt_q[if_idx][1];
      pred_target = pred_taken ? target_q[if_idx] : PC_IF + 32'd4;
   end

   always_comb begin
      ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
      mispredict  = (br_EX && (br_taken_EX != pred_taken_EX))
                 || (br_EX && br_taken_EX && pred_taken_EX && (pred_target_EX != br_target_EX))
                 || (!br_EX && pred_taken_EX);
      redirect_pc = (br_EX && br_taken_EX) ? br_target_EX : PC_EX + 32'd4;
   end

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      if (br_EX) begin
         if (ex_hit) begin
            if (br_taken_EX) begin
               target_d[ex_idx] = br_target_EX;
               if (cnt_q[ex_idx] != 2'b11) begin
                  cnt_d[ex_idx] = cnt_q[ex_idx] + 2'd1;
               end
            end else if (cnt_q[ex_idx] != 2'b00) begin
               cnt_d[ex_idx] = cnt_q[ex_idx] - 2'd1;
            end
         end else if (br_taken_EX) begin
            valid_d[ex_idx]  = 1'b1;
            tag_d[ex_idx]    = ex_tag;
            target_d[ex_idx] = br_target_EX;
            cnt_d[ex_idx]    = 2'b10;
         end
      end else if (pred_taken_EX) begin
         // A non-branch that was predicted taken means a stale alias entry.
         valid_d[ex_idx] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            cnt_q[i] <= 2'b01;
         end
      end else begin
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef BP_STATS_EN
   logic [31:0] br_count_q, br_count_d;
   logic [31:0] mispred_count_q, mispred_count_d;

   always_comb begin
      br_count_d      = br_count_q + {31'd0, br_EX};
      mispred_count_d = mispred_count_q + {31'd0, mispredict};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         br_count_q      <= '0;
         mispred_count_q <= '0;
      end else begin
         br_count_q      <= br_count_d;
         mispred_count_q <= mispred_count_d;
      end
   end

   assign br_count      = br_count_q;
   assign mispred_count = mispred_count_q;
`endif

endmodule
